// File: rtl/shift_sequencer.sv
// Iterative SLL/SRA unit: one power-of-two stage (16,8,4,2,1) per clock through a shared stage datapath.
// Latency: 5 cycles from the accepting edge to the result (1..5 with EARLY_EXIT when low amount bits are zero).
// Backpressure: busy is high while running; ctrl_start is ignored while busy, accepted in IDLE or DONE.
module shift_sequencer #(
   parameter int WIDTH      = 32,
   parameter int SHAMT_W    = 5,
   parameter int EARLY_EXIT = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_start,
   input  logic               ctrl_op,
   input  logic [WIDTH-1:0]   data_operand,
   input  logic [SHAMT_W-1:0] ctrl_shiftamt,
   output logic [WIDTH-1:0]   data_result,
   output logic               data_resultRDY,
   output logic               busy
);

   localparam int STAGE_W = $clog2(SHAMT_W);
   localparam logic [STAGE_W-1:0] STAGE_TOP = STAGE_W'(SHAMT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   working;
   logic [SHAMT_W-1:0] amt_r;
   logic               op_r;
   logic [STAGE_W-1:0] stage;

   logic [SHAMT_W-1:0] shift_dist;
   logic [WIDTH-1:0]   sll_val;
   logic [WIDTH-1:0]   sra_val;
   logic [WIDTH-1:0]   stage_val;
   logic               rem_zero;

   // Shared stage datapath: shift the working value by 2^stage when that amount bit is set.
   // The arithmetic shift is kept in its own assignment so the signed context is not lost in the mux.
   always_comb begin
      shift_dist = SHAMT_W'(1) << stage;
      sll_val    = working << shift_dist;
      sra_val    = $signed(working) >>> shift_dist;
      stage_val  = working;
      if (amt_r[stage]) begin
         stage_val = op_r ? sra_val : sll_val;
      end
   end

   // True when no amount bit at or below the current stage remains set (early-exit condition).
   always_comb begin
      rem_zero = 1'b1;
      for (int i = 0; i < SHAMT_W; i++) begin
         if ((i <= int'(stage)) && amt_r[i]) begin
            rem_zero = 1'b0;
         end
      end
   end

   // Sequencer FSM with registered outputs; a start is accepted from IDLE or DONE only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         working        <= '0;
         amt_r          <= '0;
         op_r           <= 1'b0;
         stage          <= STAGE_TOP;
         data_result    <= '0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // The RDY pulse lasts only the DONE cycle, even when a new start is taken then.
               data_resultRDY <= 1'b0;
               if (ctrl_start) begin
                  working <= data_operand;
                  amt_r   <= ctrl_shiftamt;
                  op_r    <= ctrl_op;
                  stage   <= STAGE_TOP;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if ((EARLY_EXIT != 0) && rem_zero) begin
                  data_result    <= working;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  stage          <= STAGE_TOP;
                  state          <= DONE;
               end else begin
                  working <= stage_val;
                  if (stage == '0) begin
                     // Result is captured from the final stage output on the same edge.
                     data_result    <= stage_val;
                     data_resultRDY <= 1'b1;
                     busy           <= 1'b0;
                     stage          <= STAGE_TOP;
                     state          <= DONE;
                  end else begin
                     stage <= stage - STAGE_W'(1);
                  end
               end
            end
            default: begin
               data_resultRDY <= 1'b0;
               busy           <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: one instance with EARLY_EXIT=0 and one with EARLY_EXIT=1.
// Expected results and latencies are pushed to a queue at start and popped when RDY appears.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_shift_sequencer;

   logic        clock = 1'b0;
   logic        reset;

   logic        start, op;
   logic [31:0] operand;
   logic [4:0]  amt;
   logic [31:0] result;
   logic        rdy, busy;

   logic        ee_start, ee_op;
   logic [31:0] ee_operand;
   logic [4:0]  ee_amt;
   logic [31:0] ee_result;
   logic        ee_rdy, ee_busy;

   typedef struct {
      logic [31:0] result;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(0)) dut (
      .clock(clock), .reset(reset),
      .ctrl_start(start), .ctrl_op(op), .data_operand(operand), .ctrl_shiftamt(amt),
      .data_result(result), .data_resultRDY(rdy), .busy(busy)
   );

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(1)) dut_ee (
      .clock(clock), .reset(reset),
      .ctrl_start(ee_start), .ctrl_op(ee_op), .data_operand(ee_operand), .ctrl_shiftamt(ee_amt),
      .data_result(ee_result), .data_resultRDY(ee_rdy), .busy(ee_busy)
   );

   // Reference shift: whole-amount shift in one operation.
   function automatic logic [31:0] model(input bit sra, input logic [31:0] v, input logic [4:0] a);
      logic signed [31:0] s;
      if (sra) begin
         s = v;
         s = s >>> a;
         return s;
      end
      return v << a;
   endfunction

   // Presents a start for one edge; returns #1 after the accepting edge.
   task automatic drive_start(input bit ee, input bit sra, input logic [31:0] v, input logic [4:0] a);
      if (ee) begin
         ee_start = 1'b1; ee_op = sra; ee_operand = v; ee_amt = a;
      end else begin
         start = 1'b1; op = sra; operand = v; amt = a;
      end
      @(posedge clock); #1;
      ee_start = 1'b0;
      start    = 1'b0;
   endtask

   // Waits (bounded) for RDY; counts edges since the accept edge and cycles with busy high.
   task automatic wait_rdy(input bit ee, output int cycles, output int busy_cycles, output bit seen);
      cycles = 0; busy_cycles = 0; seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ee ? ee_busy : busy) busy_cycles++;
         @(posedge clock); #1;
         cycles++;
         if (ee ? ee_rdy : rdy) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0; op = 1'b0; operand = '0; amt = '0;
      ee_start = 1'b0; ee_op = 1'b0; ee_operand = '0; ee_amt = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (ee_result !== 32'h0) begin errors++; $display("FAIL reset_ee_result: got %h expected %h", ee_result, 32'h0); end
      checks++; if (ee_busy !== 1'b0) begin errors++; $display("FAIL reset_ee_busy: got %b expected 0", ee_busy); end
      // Reset and start together: reset wins.
      start = 1'b1; operand = 32'h1; amt = 5'd1;
      @(posedge clock); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start_busy: got %b expected 0", busy); end
      start = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start_idle: got %b expected 0", busy); end
   endtask

   task automatic test_shifts;
      bit          t_op[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] t_val[4] = '{32'h0000000F, 32'h80000000, 32'h7FFFFFF0, 32'h12345678};
      logic [4:0]  t_amt[4] = '{5'd4, 5'd31, 5'd4, 5'd0};
      int cycles, bcyc;
      bit seen;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive_start(1'b0, t_op[i], t_val[i], t_amt[i]);
         exp_q.push_back('{result: model(t_op[i], t_val[i], t_amt[i]), lat: 5});
         wait_rdy(1'b0, cycles, bcyc, seen);
         e = exp_q.pop_front();
         checks++; if (!seen) begin errors++; $display("FAIL shift%0d_rdy: no RDY within bound", i); end
         checks++; if (result !== e.result) begin errors++; $display("FAIL shift%0d_result: got %h expected %h", i, result, e.result); end
         checks++; if (cycles !== e.lat) begin errors++; $display("FAIL shift%0d_latency: got %0d expected %0d", i, cycles, e.lat); end
         checks++; if (bcyc !== 5) begin errors++; $display("FAIL shift%0d_busy_cycles: got %0d expected 5", i, bcyc); end
         @(posedge clock); #1;
         checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL shift%0d_rdy_pulse: got %b expected 0", i, rdy); end
         checks++; if (result !== e.result) begin errors++; $display("FAIL shift%0d_hold: got %h expected %h", i, result, e.result); end
      end
   endtask

   task automatic test_start_in_run;
      int   pulses = 0;
      int   first  = -1;
      logic [31:0] got = '0;
      exp_t e;
      drive_start(1'b0, 1'b0, 32'h00000003, 5'd2);
      exp_q.push_back('{result: model(1'b0, 32'h00000003, 5'd2), lat: 5});
      @(posedge clock); #1;
      start = 1'b1; op = 1'b1; operand = 32'hDEADBEEF; amt = 5'd7;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 3; k < 15; k++) begin
         @(posedge clock); #1;
         if (rdy) begin
            pulses++;
            if (first < 0) begin first = k; got = result; end
         end
      end
      e = exp_q.pop_front();
      checks++; if (got !== e.result) begin errors++; $display("FAIL run_start_result: got %h expected %h", got, e.result); end
      checks++; if (first !== e.lat) begin errors++; $display("FAIL run_start_latency: got %0d expected %0d", first, e.lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL run_start_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_back_to_back;
      int cycles, bcyc;
      bit seen;
      exp_t e;
      drive_start(1'b0, 1'b0, 32'h1, 5'd1);
      exp_q.push_back('{result: model(1'b0, 32'h1, 5'd1), lat: 5});
      wait_rdy(1'b0, cycles, bcyc, seen);
      e = exp_q.pop_front();
      checks++; if (!seen || result !== e.result) begin errors++; $display("FAIL b2b_first: got %h rdy_seen %b expected %h", result, seen, e.result); end
      // Now in the DONE cycle: start the next operation right away.
      drive_start(1'b0, 1'b0, 32'h1, 5'd31);
      exp_q.push_back('{result: model(1'b0, 32'h1, 5'd31), lat: 5});
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_drop: got %b expected 0", rdy); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      wait_rdy(1'b0, cycles, bcyc, seen);
      e = exp_q.pop_front();
      checks++; if (!seen || result !== e.result) begin errors++; $display("FAIL b2b_second: got %h rdy_seen %b expected %h", result, seen, e.result); end
      checks++; if (cycles !== e.lat) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", cycles, e.lat); end
   endtask

   task automatic test_reset_mid_run;
      int   pulses = 0;
      int   cycles, bcyc;
      bit   seen;
      exp_t e;
      drive_start(1'b0, 1'b0, 32'h000000FF, 5'd3);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected %h", result, 32'h0); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", rdy); end
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (rdy) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_rdy: got %0d pulses expected 0", pulses); end
      drive_start(1'b0, 1'b0, 32'h5, 5'd2);
      exp_q.push_back('{result: model(1'b0, 32'h5, 5'd2), lat: 5});
      wait_rdy(1'b0, cycles, bcyc, seen);
      e = exp_q.pop_front();
      checks++; if (!seen || result !== e.result) begin errors++; $display("FAIL midrst_after: got %h rdy_seen %b expected %h", result, seen, e.result); end
      checks++; if (cycles !== e.lat) begin errors++; $display("FAIL midrst_after_latency: got %0d expected %0d", cycles, e.lat); end
   endtask

   task automatic test_early_exit;
      bit          t_op[3]  = '{1'b0, 1'b0, 1'b1};
      logic [31:0] t_val[3] = '{32'h0000000A, 32'h0000000A, 32'h80000000};
      logic [4:0]  t_amt[3] = '{5'd0, 5'd16, 5'd31};
      int          t_lat[3] = '{1, 2, 5};
      int cycles, bcyc;
      bit seen;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive_start(1'b1, t_op[i], t_val[i], t_amt[i]);
         exp_q.push_back('{result: model(t_op[i], t_val[i], t_amt[i]), lat: t_lat[i]});
         wait_rdy(1'b1, cycles, bcyc, seen);
         e = exp_q.pop_front();
         checks++; if (!seen) begin errors++; $display("FAIL early%0d_rdy: no RDY within bound", i); end
         checks++; if (ee_result !== e.result) begin errors++; $display("FAIL early%0d_result: got %h expected %h", i, ee_result, e.result); end
         checks++; if (cycles !== e.lat) begin errors++; $display("FAIL early%0d_latency: got %0d expected %0d", i, cycles, e.lat); end
         checks++; if (bcyc !== e.lat) begin errors++; $display("FAIL early%0d_busy_cycles: got %0d expected %0d", i, bcyc, e.lat); end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      test_reset();
      test_shifts();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      test_early_exit();
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the processor's execute stage.
- Performs SLL or SRA on a 32-bit operand by walking the power-of-two stages 16, 8, 4, 2, 1, one stage per clock.
- Each stage either applies its fixed shift or passes the value through, according to the matching shift-amount bit.
- Shares one stage datapath across all five steps and uses a start/ready handshake with the pipeline stall logic.

Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported.
- SHAMT_W, 5: shift-amount width, equal to log2(WIDTH).
- EARLY_EXIT, 0: if 1, the sequence finishes as soon as all remaining shift-amount bits are zero.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  request to start a shift; sampled only when not busy.
- ctrl_op  in  1  0 = SLL (fill with zeros), 1 = SRA (fill with the sign bit).
- data_operand  in  WIDTH  value to shift; captured on the accepting edge.
- ctrl_shiftamt  in  SHAMT_W  shift amount; captured on the accepting edge.
- data_result  out  WIDTH  shifted value; held stable until the next accepted start.
- data_resultRDY  out  1  one-cycle pulse: data_result is valid.
- busy  out  1  high while a shift is in progress; ctrl_start is ignored while high.

Behaviour:
- Reset is synchronous and active-high on clock. On reset: state=IDLE, data_result=0, data_resultRDY=0, busy=0, stage counter=SHAMT_W-1, internal registers cleared.
- States:
  - IDLE: waiting for a start.
  - RUN: executing stages.
  - DONE: result ready.
- IDLE or DONE with ctrl_start=1 at an edge:
  - Latch data_operand into the working register, ctrl_shiftamt into amt_r, ctrl_op into op_r.
  - Set stage=4 and go to RUN.
- Acceptance in DONE gives back-to-back operation; the RDY pulse for the previous result is still emitted that cycle.
- RUN, each edge:
  - If amt_r[stage]=1, working <= working shifted by 2^stage. SLL shifts left and fills with zeros. SRA shifts right and fills with working[WIDTH-1].
  - If amt_r[stage]=0, the working register is unchanged.
  - If stage=0, go to DONE. Otherwise stage decrements.
- EARLY_EXIT=1: in RUN, if amt_r[stage:0]==0, go to DONE on that edge and leave working unchanged.
- DONE: data_result <= working is registered on entry. data_resultRDY=1 for exactly this cycle. The next state is IDLE unless a start is accepted.
- busy=1 exactly while state=RUN. A start in RUN is dropped and does not corrupt the captured inputs.
- Latency with EARLY_EXIT=0: fixed. If start is accepted at edge N, the stages run at edges N+1..N+5 and data_resultRDY is high in the cycle after edge N+5.
- Latency with EARLY_EXIT=1: for shiftamt=0, data_resultRDY is high in the cycle after edge N+1.
- Shift amount 0 returns the operand unchanged. Shift amount 31 fully applies every stage; no overflow or exception is signalled.
- Reset asserted mid-RUN: the operation is abandoned. The next cycle is IDLE with all outputs 0 and no RDY pulse.
- Reset and ctrl_start in the same cycle: reset wins.

Test Plan:
- Reset, then SLL of 0x0000000F by 4 (EARLY_EXIT=0) -> data_result=0x000000F0; RDY pulses exactly 5 cycles after the start edge; busy high for 5 cycles.
- SRA of 0x80000000 by 31 -> 0xFFFFFFFF. SRA of 0x7FFFFFF0 by 4 -> 0x07FFFFFF. SLL of 0x12345678 by 0 -> 0x12345678 with the full 5-cycle latency.
- ctrl_start pulsed mid-RUN with a different operand/amount -> first result unchanged; no second RDY.
- Start accepted in the DONE cycle (SLL 0x1 by 1, then SLL 0x1 by 31) -> RDY for 0x00000002, then 5 cycles later RDY for 0x80000000.
- Reset asserted at the third RUN cycle -> next cycle IDLE, data_result=0, busy=0, no RDY. A subsequent start behaves normally.
- EARLY_EXIT=1: SLL 0xA by 0 -> RDY the cycle after the first RUN edge. SLL 0xA by 16 -> RDY after 2 RUN edges with result 0x000A0000.
